// File: rtl/axi_mem_slave_if.sv
// AXI-style burst memory port bundle: address, data and response channels for one slave.
interface axi_mem_slave_if #(
  parameter int AW = 32
);
  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [1:0]    awburst;
  logic          wvalid;
  logic          wready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wlast;
  logic          bvalid;
  logic          bready;
  logic [1:0]    bresp;
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [1:0]    arburst;
  logic          rvalid;
  logic          rready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rlast;

  modport slave (
    input  awvalid, awaddr, awlen, awburst,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arlen, arburst,
    input  rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp, rlast
  );

  modport master (
    output awvalid, awaddr, awlen, awburst,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arlen, arburst,
    output rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi_mem_slave.sv
// Word-addressed burst memory slave (FIXED/INCR/WRAP); read data one cycle after AR, outputs held under rready/bready backpressure.
// Optional AXI_SLV_ADDR_CHECK_EN: beats at or above MEM_DEPTH get SLVERR and never touch memory.
module axi_mem_slave #(
  parameter int MEM_DEPTH = 256,
  parameter int AW        = 32
) (
  input  logic            clk,
  input  logic            reset,
  axi_mem_slave_if.slave  s_axi
);

  localparam int IW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // WRAP windows are only legal for 2/4/8/16 beats; anything else walks like INCR.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                               input logic [7:0]    len,
                                               input logic [1:0]    burst);
    logic [AW-1:0] inc;
    logic [AW-1:0] mask;
    inc       = a + AW'(1);
    mask      = AW'(len);
    next_addr = inc;
    if (burst == 2'b00)
      next_addr = a;
    else if (burst == 2'b10 &&
             (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      next_addr = (a & ~mask) | (inc & mask);
  endfunction

  logic [31:0] mem [MEM_DEPTH];

  w_state_t      w_state, w_next;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_len;
  logic [1:0]    w_burst;
  logic [7:0]    w_cnt;
  logic          w_err;
  logic [1:0]    bresp_q;
  logic          awready_c, wready_c, bvalid_c;
  logic          aw_hs, w_hs, w_at_len, w_final, w_mis, w_ok;
  logic [IW-1:0] w_idx;

  r_state_t      r_state, r_next;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_len;
  logic [1:0]    r_burst;
  logic [7:0]    r_cnt;
  logic [31:0]   rdata_q;
  logic [1:0]    rresp_q;
  logic          rlast_q;
  logic          arready_c, rvalid_c;
  logic          ar_hs, r_hs, r_load, r_ok;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_len;
  logic [1:0]    rd_burst;
  logic [IW-1:0] rd_idx;

  assign aw_hs    = s_axi.awvalid && awready_c;
  assign w_hs     = s_axi.wvalid && wready_c;
  assign w_at_len = (w_cnt == w_len);
  assign w_final  = s_axi.wlast || w_at_len;
  assign w_mis    = s_axi.wlast != w_at_len;
  assign w_idx    = w_addr[IW-1:0];

  // Read side loads from the AR channel in idle, from its own pointer mid-burst.
  assign rd_addr  = (r_state == R_IDLE) ? s_axi.araddr  : r_addr;
  assign rd_len   = (r_state == R_IDLE) ? s_axi.arlen   : r_len;
  assign rd_burst = (r_state == R_IDLE) ? s_axi.arburst : r_burst;
  assign rd_idx   = rd_addr[IW-1:0];
  assign ar_hs    = s_axi.arvalid && arready_c;
  assign r_hs     = s_axi.rready && rvalid_c;
  assign r_load   = ar_hs || (r_hs && !rlast_q);

`ifdef AXI_SLV_ADDR_CHECK_EN
  assign w_ok = (w_addr < AW'(MEM_DEPTH));
  assign r_ok = (rd_addr < AW'(MEM_DEPTH));
`else
  assign w_ok = 1'b1;
  assign r_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next    = w_state;
    awready_c = 1'b0;
    wready_c  = 1'b0;
    bvalid_c  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready_c = 1'b1;
        if (s_axi.awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        wready_c = 1'b1;
        if (s_axi.wvalid && w_final) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid_c = 1'b1;
        if (s_axi.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_addr  <= '0;
      w_len   <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      bresp_q <= 2'b00;
    end else begin
      if (aw_hs) begin
        w_addr  <= s_axi.awaddr;
        w_len   <= s_axi.awlen;
        w_burst <= s_axi.awburst;
        w_cnt   <= '0;
        w_err   <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= next_addr(w_addr, w_len, w_burst);
        w_cnt  <= w_cnt + 8'd1;
        if (w_final) bresp_q <= (w_err || w_mis || !w_ok) ? 2'b10 : 2'b00;
        else         w_err   <= w_err || !w_ok;
      end
    end
  end

  // Storage is deliberately outside reset; a beat landing with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && w_hs && w_ok) begin
      for (int b = 0; b < 4; b++)
        if (s_axi.wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next    = r_state;
    arready_c = 1'b0;
    rvalid_c  = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready_c = 1'b1;
        if (s_axi.arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid_c = 1'b1;
        if (s_axi.rready && rlast_q) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Nonblocking read of mem returns pre-write data on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      rdata_q <= '0;
      rresp_q <= 2'b00;
      rlast_q <= 1'b0;
    end else begin
      if (r_load) begin
        rdata_q <= r_ok ? mem[rd_idx] : 32'd0;
        rresp_q <= r_ok ? 2'b00 : 2'b10;
        r_addr  <= next_addr(rd_addr, rd_len, rd_burst);
      end
      if (ar_hs) begin
        r_len   <= s_axi.arlen;
        r_burst <= s_axi.arburst;
        r_cnt   <= '0;
        rlast_q <= (s_axi.arlen == 8'd0);
      end else if (r_hs) begin
        if (rlast_q) begin
          rlast_q <= 1'b0;
        end else begin
          r_cnt   <= r_cnt + 8'd1;
          rlast_q <= ((r_cnt + 8'd1) == r_len);
        end
      end
    end
  end

  assign s_axi.awready = awready_c;
  assign s_axi.wready  = wready_c;
  assign s_axi.bvalid  = bvalid_c;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_c;
  assign s_axi.rvalid  = rvalid_c;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rlast   = rlast_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: bursts, strobes, backpressure, protocol errors, reset abort.
module tb_axi_mem_slave;

  localparam int LIM = 100;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi_mem_slave_if #(.AW(32)) bus ();

  axi_mem_slave #(.MEM_DEPTH(256), .AW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .s_axi (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];
  logic [1:0]  rrsp [16];
  logic        rlst [16];
  logic [1:0]  resp;
  logic [31:0] d;
  logic [1:0]  rs;
  logic        l;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All channel tasks start and end on a falling edge.
  task automatic aw_send(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b);
    int n = 0;
    bus.awvalid = 1'b1; bus.awaddr = a; bus.awlen = len; bus.awburst = b;
    while (bus.awready !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) chk("aw_timeout", 32'(bus.awready), 32'd1);
    @(negedge clk);
    bus.awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb; bus.wlast = last;
    while (bus.wready !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) chk("w_timeout", 32'(bus.wready), 32'd1);
    @(negedge clk);
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic b_take(input int hold, output logic [1:0] r);
    int n = 0;
    bus.bready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      chk("b_hold_valid", 32'(bus.bvalid), 32'd1);
      @(negedge clk);
    end
    bus.bready = 1'b1;
    while (bus.bvalid !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) chk("b_timeout", 32'(bus.bvalid), 32'd1);
    r = bus.bresp;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b);
    int n = 0;
    bus.arvalid = 1'b1; bus.araddr = a; bus.arlen = len; bus.arburst = b;
    while (bus.arready !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) chk("ar_timeout", 32'(bus.arready), 32'd1);
    @(negedge clk);
    bus.arvalid = 1'b0;
  endtask

  task automatic r_take(output logic [31:0] data, output logic [1:0] rr, output logic last);
    int n = 0;
    bus.rready = 1'b1;
    while (bus.rvalid !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) chk("r_timeout", 32'(bus.rvalid), 32'd1);
    data = bus.rdata; rr = bus.rresp; last = bus.rlast;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b,
                           input int nb, input int last_idx, input logic [3:0] strb,
                           input int hold, output logic [1:0] r);
    aw_send(a, len, b);
    for (int i = 0; i < nb; i++) w_beat(wbuf[i], strb, i == last_idx);
    b_take(hold, r);
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b,
                          input int stall_beat, input int stall_cyc, input logic [31:0] stall_exp);
    ar_send(a, len, b);
    chk("r_latency", 32'(bus.rvalid), 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        for (int k = 0; k < stall_cyc; k++) begin
          chk("r_stall_data", bus.rdata, stall_exp);
          chk("r_stall_valid", 32'(bus.rvalid), 32'd1);
          @(negedge clk);
        end
      end
      r_take(rbuf[i], rrsp[i], rlst[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.awvalid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awburst = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arlen = 0; bus.arburst = 0; bus.rready = 0;
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(bus.awready), 32'd1);
    chk("rst_arready", 32'(bus.arready), 32'd1);
    chk("rst_wready",  32'(bus.wready),  32'd0);
    chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
    chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
    chk("rst_rlast",   32'(bus.rlast),   32'd0);
    chk("rst_bresp",   32'(bus.bresp),   32'd0);
    chk("rst_rresp",   32'(bus.rresp),   32'd0);
    chk("rst_rdata",   bus.rdata,        32'd0);
    reset = 1'b0;
    @(negedge clk);

    // INCR write/read of 5..9 at word 1
    for (int i = 0; i < 5; i++) wbuf[i] = 32'(5 + i);
    axi_write(32'd1, 8'd4, INCR, 5, 4, 4'hF, 0, resp);
    chk("incr_bresp", 32'(resp), 32'd0);
    axi_read(32'd1, 8'd4, INCR, -1, 0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("incr_rdata", rbuf[i], 32'(5 + i));
      chk("incr_rlast", 32'(rlst[i]), (i == 4) ? 32'd1 : 32'd0);
      chk("incr_rresp", 32'(rrsp[i]), 32'd0);
    end

    // rready low for 3 cycles on beat 2 (word 3 = 7)
    axi_read(32'd1, 8'd4, INCR, 2, 3, 32'd7);
    for (int i = 0; i < 5; i++) chk("stall_rdata", rbuf[i], 32'(5 + i));

    // WRAP read over words 4..7
    wbuf[0] = 32'h40; wbuf[1] = 32'h50; wbuf[2] = 32'h60; wbuf[3] = 32'h70;
    axi_write(32'd4, 8'd3, INCR, 4, 3, 4'hF, 0, resp);
    axi_read(32'd6, 8'd3, WRAP, -1, 0, 32'd0);
    chk("wrap_r0", rbuf[0], 32'h60);
    chk("wrap_r1", rbuf[1], 32'h70);
    chk("wrap_r2", rbuf[2], 32'h40);
    chk("wrap_r3", rbuf[3], 32'h50);
    chk("wrap_rlast", 32'(rlst[3]), 32'd1);

    // WRAP write at 13 with bready held low
    wbuf[0] = 32'hA1; wbuf[1] = 32'hA2; wbuf[2] = 32'hA3; wbuf[3] = 32'hA4;
    axi_write(32'd13, 8'd3, WRAP, 4, 3, 4'hF, 3, resp);
    chk("wrapw_bresp", 32'(resp), 32'd0);
    axi_read(32'd12, 8'd3, INCR, -1, 0, 32'd0);
    chk("wrapw_12", rbuf[0], 32'hA4);
    chk("wrapw_13", rbuf[1], 32'hA1);
    chk("wrapw_15", rbuf[3], 32'hA3);

    // WRAP with len 2 behaves as INCR
    axi_read(32'd5, 8'd2, WRAP, -1, 0, 32'd0);
    chk("wrap3_r0", rbuf[0], 32'h50);
    chk("wrap3_r2", rbuf[2], 32'h70);

    // FIXED write leaves only the last beat
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3;
    axi_write(32'd20, 8'd2, FIXED, 3, 2, 4'hF, 0, resp);
    axi_read(32'd20, 8'd1, FIXED, -1, 0, 32'd0);
    chk("fixed_r0", rbuf[0], 32'd3);
    chk("fixed_r1", rbuf[1], 32'd3);

    // Byte strobes
    wbuf[0] = 32'd0;
    axi_write(32'd30, 8'd0, INCR, 1, 0, 4'hF, 0, resp);
    wbuf[0] = 32'hAABBCCDD;
    axi_write(32'd30, 8'd0, INCR, 1, 0, 4'b0101, 0, resp);
    axi_read(32'd30, 8'd0, INCR, -1, 0, 32'd0);
    chk("strb_data", rbuf[0], 32'h00BB00DD);

    // Early wlast
    wbuf[0] = 32'hB0; wbuf[1] = 32'hB1;
    axi_write(32'd40, 8'd3, INCR, 2, 1, 4'hF, 0, resp);
    chk("early_bresp", 32'(resp), 32'd2);
    chk("early_awready", 32'(bus.awready), 32'd1);
    axi_read(32'd40, 8'd1, INCR, -1, 0, 32'd0);
    chk("early_w41", rbuf[1], 32'hB1);

    // Missing wlast at the final beat
    aw_send(32'd44, 8'd1, INCR);
    w_beat(32'hC0, 4'hF, 1'b0);
    w_beat(32'hC1, 4'hF, 1'b0);
    chk("late_wready", 32'(bus.wready), 32'd0);
    chk("late_bvalid", 32'(bus.bvalid), 32'd1);
    b_take(0, resp);
    chk("late_bresp", 32'(resp), 32'd2);
    axi_read(32'd44, 8'd1, INCR, -1, 0, 32'd0);
    chk("late_w45", rbuf[1], 32'hC1);

    // Same-cycle write and read load of word 50
    wbuf[0] = 32'h11;
    axi_write(32'd50, 8'd0, INCR, 1, 0, 4'hF, 0, resp);
    aw_send(32'd50, 8'd0, INCR);
    bus.wvalid = 1'b1; bus.wdata = 32'h22; bus.wstrb = 4'hF; bus.wlast = 1'b1;
    bus.arvalid = 1'b1; bus.araddr = 32'd50; bus.arlen = 8'd0; bus.arburst = INCR;
    chk("cc_wready", 32'(bus.wready), 32'd1);
    chk("cc_arready", 32'(bus.arready), 32'd1);
    @(negedge clk);
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.arvalid = 1'b0;
    r_take(d, rs, l);
    chk("cc_old_data", d, 32'h11);
    b_take(0, resp);
    axi_read(32'd50, 8'd0, INCR, -1, 0, 32'd0);
    chk("cc_new_data", rbuf[0], 32'h22);

    // Reset during the 3rd write beat
    aw_send(32'd60, 8'd4, INCR);
    w_beat(32'h61, 4'hF, 1'b0);
    w_beat(32'h62, 4'hF, 1'b0);
    bus.wvalid = 1'b1; bus.wdata = 32'h63; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; bus.wvalid = 1'b0;
    chk("mid_rst_awready", 32'(bus.awready), 32'd1);
    chk("mid_rst_wready", 32'(bus.wready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("mid_rst_bvalid", 32'(bus.bvalid), 32'd0);
      @(negedge clk);
    end
    axi_read(32'd60, 8'd1, INCR, -1, 0, 32'd0);
    chk("mid_rst_w60", rbuf[0], 32'h61);
    chk("mid_rst_w61", rbuf[1], 32'h62);

    // Burst crossing the top of memory
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(32'hE0 + i);
    axi_write(32'd254, 8'd3, INCR, 4, 3, 4'hF, 0, resp);
    axi_read(32'd254, 8'd3, INCR, -1, 0, 32'd0);
    chk("top_w254", rbuf[0], 32'hE0);
    chk("top_w255", rbuf[1], 32'hE1);
`ifdef AXI_SLV_ADDR_CHECK_EN
    chk("top_bresp", 32'(resp), 32'd2);
    chk("top_r256", rbuf[2], 32'd0);
    chk("top_rresp256", 32'(rrsp[2]), 32'd2);
    axi_read(32'd0, 8'd1, INCR, -1, 0, 32'd0);
    chk("top_w0", rbuf[0], 32'd0);
    chk("top_w1", rbuf[1], 32'd5);
`else
    chk("top_bresp", 32'(resp), 32'd0);
    chk("top_r256", rbuf[2], 32'hE2);
    chk("top_rresp256", 32'(rrsp[2]), 32'd0);
    axi_read(32'd0, 8'd1, INCR, -1, 0, 32'd0);
    chk("top_w0", rbuf[0], 32'hE2);
    chk("top_w1", rbuf[1], 32'hE3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, meaning the number of 32-bit memory words (power of two).
REQ-002 SHALL have parameter AW, default 32, meaning the address width; addresses are word addresses.
REQ-003 clk  input  1  sole clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s_axi_awvalid  input  1  write address valid.
REQ-006 s_axi_awready  output  1  write address ready.
REQ-007 s_axi_awaddr  input  AW  burst start word address.
REQ-008 s_axi_awlen  input  8  beats minus one.
REQ-009 s_axi_awburst  input  2  00 FIXED, 01 INCR, 10 WRAP.
REQ-010 s_axi_wvalid  input  1  write data valid.
REQ-011 s_axi_wready  output  1  write data ready.
REQ-012 s_axi_wdata  input  32  write data.
REQ-013 s_axi_wstrb  input  4  byte enables.
REQ-014 s_axi_wlast  input  1  final write beat.
REQ-015 s_axi_bvalid  output  1  write response valid.
REQ-016 s_axi_bready  input  1  write response accepted.
REQ-017 s_axi_bresp  output  2  00 OKAY, 10 SLVERR.
REQ-018 s_axi_arvalid  input  1  read address valid.
REQ-019 s_axi_arready  output  1  read address ready.
REQ-020 s_axi_araddr  input  AW  read start word address.
REQ-021 s_axi_arlen  input  8  beats minus one.
REQ-022 s_axi_arburst  input  2  read burst type, same encoding as awburst.
REQ-023 s_axi_rvalid  output  1  read data valid.
REQ-024 s_axi_rready  input  1  read data accepted.
REQ-025 s_axi_rdata  output  32  read data.
REQ-026 s_axi_rresp  output  2  per-beat read response.
REQ-027 s_axi_rlast  output  1  final read beat.

Function
REQ-028 Write FSM SHALL use states W_IDLE (awready=1), W_DATA (wready=1) and W_RESP (bvalid=1), with transitions W_IDLE->W_DATA on the AW handshake, W_DATA->W_RESP on a W handshake with wlast=1 or with the beat count reaching awlen, and W_RESP->W_IDLE on bready.
REQ-029 On each W handshake, the block SHALL update only the bytes whose wstrb bit is 1 at the current word address, then advance the address.
REQ-030 Address advance SHALL be: FIXED, unchanged; INCR, +1 modulo 2^AW; WRAP, +1 within an aligned window of len+1 words (wraps from the top of the window to its base).
REQ-031 WRAP with len not in {1,3,7,15} SHALL be treated as INCR.
REQ-032 A W beat with wlast=1 before beat awlen SHALL terminate the burst; a beat at count awlen with wlast=0 SHALL also terminate it; both cases set bresp=SLVERR.
REQ-033 Read FSM SHALL use states R_IDLE (arready=1) and R_DATA (rvalid=1), moving R_IDLE->R_DATA on the AR handshake; rdata/rlast SHALL be valid one cycle after the AR handshake.
REQ-034 In R_DATA, rdata, rresp and rlast SHALL hold stable while rready=0; on an R handshake the next beat SHALL appear in the following cycle; the handshake with rlast=1 SHALL return the FSM to R_IDLE.
REQ-035 Read and write channels SHALL operate concurrently; when a read beat is loaded from an address written in the same cycle, the read SHALL return the old data.
REQ-036 Without REQ-039, memory index SHALL be the address modulo MEM_DEPTH and every response SHALL be OKAY.

Reset
REQ-037 On reset, both FSMs SHALL enter idle: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=00, rresp=00 and rdata=0, including when reset arrives mid-burst (the partial burst is abandoned and no response is issued).
REQ-038 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-039 With AXI_SLV_ADDR_CHECK_EN defined, any beat whose address is >= MEM_DEPTH SHALL return SLVERR and perform no memory write (read returns 0); any SLVERR beat in a write burst makes bresp=SLVERR. Without the macro, REQ-036 applies.

Verification
REQ-040 INCR write at address 1, awlen 4, data 5..9, wstrb 1111 -> bresp OKAY; INCR read at address 1, arlen 4 -> 5,6,7,8,9 with rlast on the 5th beat.
REQ-041 WRAP read at address 6, arlen 3 -> words 6,7,4,5 returned in that order.
REQ-042 Write of 0xAABBCCDD with wstrb 0101 over prior 0 -> readback 0x00BB00DD.
REQ-043 rready held low 3 cycles on beat 2 -> rdata stable and no beat lost; bready held low -> bvalid held high.
REQ-044 Reset asserted during the 3rd write beat -> bvalid never asserted, awready=1 the next cycle, and the beats already written persist in memory.
REQ-045 With the macro defined and MEM_DEPTH 256, INCR write at address 254, awlen 3 -> bresp SLVERR and words 254,255 written; without the macro, words 0,1 are also written and bresp is OKAY.
